button_debouncer_multi: RTL and testbench
=========================================

Name: button_debouncer_multi

Overview:
Parametrised N-channel successor to the single-channel debouncer. It synchronises raw button inputs and debounces them against a shared microsecond timebase. Per channel it emits press/release pulses, a stable level, short/long-press classification and optional auto-repeat. It sits between the board button pins and the UI logic that drives the display decoder and LCD controller.

Parameters:
N_CH, 4, number of button channels
FREQ, 50000000, CLK frequency in Hz; must be a multiple of 1000000
DEBOUNCE_US, 10000, required stable time in µs before a level change is accepted (>=1)
LONG_MS, 800, hold time in ms that classifies a press as long (>=1)
REPEAT_MS, 150, auto-repeat period in ms after long press (>=1)
REPEAT_MASK, {N_CH{1'b1}}, per-channel auto-repeat enable
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
switch_input  input  N_CH  raw button pins
level  output  N_CH  debounced state, 1 = pressed
trans_up  output  N_CH  1-cycle pulse on accepted press
trans_dn  output  N_CH  1-cycle pulse on accepted release
short_press  output  N_CH  1-cycle pulse on release if LONG_MS not reached
long_press  output  N_CH  1-cycle pulse when hold reaches LONG_MS
repeat_tick  output  N_CH  1-cycle pulse every REPEAT_MS after long_press
any_event  output  1  OR of all pulse outputs, same cycle

Behaviour:
- Reset: all outputs 0; level = released; synchronisers, counters, prescalers cleared. Async assert, sync release.
- Input path: 2-flop synchroniser per channel, then polarity normalisation (pressed=1 internally).
- Timebase: shared prescaler; us_tick 1 cycle every FREQ/1e6 clocks. ms prescaler counts 1000 us_ticks; ms_tick coincides with the 1000th us_tick. Both free-running from reset.
- Debounce per channel: deb_cnt clears whenever sync == level. On each us_tick with sync != level it increments. On the us_tick where deb_cnt == DEBOUNCE_US-1 and mismatch persists, level toggles at that edge. Any bounce back clears deb_cnt.
- Press/release latency: 2 sync cycles + between DEBOUNCE_US-1 and DEBOUNCE_US µs (tick phase). trans_up/trans_dn are registered and assert in the same cycle level changes.
- Hold FSM per channel: RELEASED -> PRESSED on press; PRESSED -> HELD on long_press; PRESSED/HELD -> RELEASED on release.
- hold_cnt clears on entry to PRESSED and increments on ms_tick. When it reaches LONG_MS: long_press pulse, go to HELD, clear hold_cnt.
- In HELD with REPEAT_MASK bit set: repeat_tick each time hold_cnt reaches REPEAT_MS, then clear. With the bit clear, hold_cnt stops (no wrap, no pulses).
- Release from PRESSED: trans_dn + short_press in the same cycle. Release from HELD: trans_dn only.
- Simultaneous events: a release has priority over long_press/repeat_tick in the same cycle; that ms_tick produces no long/repeat pulse. Channels are fully independent; multiple channels may pulse in one cycle.
- Counter widths: $clog2 of each max count; no overflow possible.
- Button held through reset: after RST_N release, level=0, so the held button debounces as a new press and trans_up fires after the normal latency.
- Reset mid-debounce or mid-hold: state is lost; no pulses generated by reset itself.

Test Plan:
- Sim params FREQ=4000000, DEBOUNCE_US=5, LONG_MS=2, REPEAT_MS=1, ACTIVE_LOW=1. Drive ch0 low (clean) -> trans_up[0] single pulse 18–22 cycles later, level[0]=1; drive high -> trans_dn[0] + short_press[0] same cycle, level[0]=0.
- Ch1 bounce: toggle every 8 cycles for 60 cycles, then hold low -> no pulse during bounce; exactly one trans_up[1] about 20 cycles after the last edge.
- Ch2 held 10 ms -> long_press[2] at about 2 ms after trans_up, then repeat_tick[2] at 3,4,…,10 ms (8 pulses); release -> trans_dn[2], no short_press.
- REPEAT_MASK=4'b0111, ch3 held 6 ms -> one long_press[3], zero repeat_tick[3].
- Ch0 and ch1 pressed in the same cycle -> both trans_up in the same cycle, any_event single-cycle high.
- Hold ch0 low, assert RST_N mid-hold -> all outputs 0 immediately; after deassert, trans_up[0] reissued after the debounce latency.

Source files
------------

// File: rtl/button_debouncer_multi.sv
// button_debouncer_multi: N-channel synchronised debouncer with press/release pulses, short/long press and auto-repeat
module button_debouncer_multi #(
    parameter int N_CH = 4,
    parameter int FREQ = 50000000,
    parameter int DEBOUNCE_US = 10000,
    parameter int LONG_MS = 800,
    parameter int REPEAT_MS = 150,
    parameter logic [N_CH-1:0] REPEAT_MASK = {N_CH{1'b1}},
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [N_CH-1:0] switch_input,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] trans_up,
    output logic [N_CH-1:0] trans_dn,
    output logic [N_CH-1:0] short_press,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] repeat_tick,
    output logic            any_event
);
    localparam int US_DIV = FREQ / 1000000;
    localparam int UW = US_DIV > 1 ? $clog2(US_DIV) : 1;
    localparam int MW = $clog2(1000);
    localparam int DW = DEBOUNCE_US > 1 ? $clog2(DEBOUNCE_US) : 1;
    localparam int HMAX = LONG_MS > REPEAT_MS ? LONG_MS : REPEAT_MS;
    localparam int HW = $clog2(HMAX + 1);

    typedef enum logic [1:0] {RELEASED, PRESSED, HELD} hold_t;

    logic [1:0]      rst_ff;
    logic            rst_n_s;
    logic [N_CH-1:0] sync1, sync2, pressed, accept;
    logic [UW-1:0]   us_cnt;
    logic [MW-1:0]   ms_cnt;
    logic            us_tick, ms_tick;
    logic [DW-1:0]   deb_cnt [N_CH];
    logic [HW-1:0]   hold_cnt [N_CH];
    hold_t           st [N_CH];

    // reset asserts immediately but releases on a clock edge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rst_ff <= '0;
        else rst_ff <= {rst_ff[0], 1'b1};
    end
    assign rst_n_s = rst_ff[1];

    always_ff @(posedge CLK or negedge rst_n_s) begin
        if (!rst_n_s) begin
            sync1 <= {N_CH{ACTIVE_LOW}};
            sync2 <= {N_CH{ACTIVE_LOW}};
            us_cnt <= '0;
            ms_cnt <= '0;
        end else begin
            sync1 <= switch_input;
            sync2 <= sync1;
            us_cnt <= us_tick ? '0 : us_cnt + 1'b1;
            if (us_tick) ms_cnt <= ms_tick ? '0 : ms_cnt + 1'b1;
        end
    end

    assign pressed = ACTIVE_LOW ? ~sync2 : sync2;
    assign us_tick = us_cnt == UW'(US_DIV - 1);
    assign ms_tick = us_tick && ms_cnt == MW'(999);
    assign any_event = |{trans_up, trans_dn, short_press, long_press, repeat_tick};

    always_comb
        for (int i = 0; i < N_CH; i++)
            accept[i] = us_tick && pressed[i] != level[i] && deb_cnt[i] == DW'(DEBOUNCE_US - 1);

    // an accepted level change takes priority over any hold event on the same ms tick
    always_ff @(posedge CLK or negedge rst_n_s) begin
        if (!rst_n_s) begin
            level <= '0;
            trans_up <= '0;
            trans_dn <= '0;
            short_press <= '0;
            long_press <= '0;
            repeat_tick <= '0;
            for (int i = 0; i < N_CH; i++) begin
                st[i] <= RELEASED;
                deb_cnt[i] <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            trans_up <= '0;
            trans_dn <= '0;
            short_press <= '0;
            long_press <= '0;
            repeat_tick <= '0;
            for (int i = 0; i < N_CH; i++) begin
                deb_cnt[i] <= (pressed[i] == level[i] || accept[i]) ? '0 : us_tick ? deb_cnt[i] + 1'b1 : deb_cnt[i];
                if (accept[i]) begin
                    level[i] <= pressed[i];
                    trans_up[i] <= pressed[i];
                    trans_dn[i] <= !pressed[i];
                    short_press[i] <= !pressed[i] && st[i] == PRESSED;
                    st[i] <= pressed[i] ? PRESSED : RELEASED;
                    hold_cnt[i] <= '0;
                end else if (ms_tick && st[i] == PRESSED) begin
                    if (hold_cnt[i] == HW'(LONG_MS - 1)) begin
                        long_press[i] <= 1'b1;
                        st[i] <= HELD;
                        hold_cnt[i] <= '0;
                    end else hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end else if (ms_tick && st[i] == HELD && REPEAT_MASK[i]) begin
                    if (hold_cnt[i] == HW'(REPEAT_MS - 1)) begin
                        repeat_tick[i] <= 1'b1;
                        hold_cnt[i] <= '0;
                    end else hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_button_debouncer_multi.sv
// tb_button_debouncer_multi: randomized and directed checks against a timestamp-based reference model
module tb_button_debouncer_multi;
    localparam int N = 4, DIV = 4, DEB = 5, LONG = 2, REP = 1, MSC = DIV * 1000;
    localparam logic [N-1:0] MASK = 4'b0111;
    localparam logic [6*N:0] PM = {{N{1'b0}}, {(5*N+1){1'b1}}};

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] sw = '1;
    logic [N-1:0] level, trans_up, trans_dn, short_press, long_press, repeat_tick;
    logic any_event;
    logic [6*N:0] obs, expv;
    int checks = 0, errors = 0;

    button_debouncer_multi #(
        .N_CH(N), .FREQ(4000000), .DEBOUNCE_US(DEB), .LONG_MS(LONG), .REPEAT_MS(REP),
        .REPEAT_MASK(MASK), .ACTIVE_LOW(1'b1)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .switch_input(sw), .level(level), .trans_up(trans_up),
        .trans_dn(trans_dn), .short_press(short_press), .long_press(long_press),
        .repeat_tick(repeat_tick), .any_event(any_event)
    );

    always #5 clk = ~clk;

    // model: edges counted from internal reset release; us edge when n%DIV==0, ms edge when n%MSC==0
    int n = 0, skip = 2, el;
    bit h1 [N], h2 [N], s, acc;
    int la [N], st [N], ref_ms [N];
    logic [N-1:0] e_lv = '0, e_up = '0, e_dn = '0, e_sh = '0, e_lg = '0, e_rp = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        e_up = '0; e_dn = '0; e_sh = '0; e_lg = '0; e_rp = '0;
        if (!rst_n) begin
            n = 0; skip = 2; e_lv = '0;
            for (int c = 0; c < N; c++) begin
                h1[c] = 0; h2[c] = 0; la[c] = 0; st[c] = 0; ref_ms[c] = 0;
            end
        end else if (skip > 0) skip--;
        else begin
            n++;
            for (int c = 0; c < N; c++) begin
                s = h2[c]; h2[c] = h1[c]; h1[c] = !sw[c]; acc = 0;
                if (s == e_lv[c]) la[c] = n;
                else if (n % DIV == 0 && n / DIV - la[c] / DIV >= DEB) begin
                    acc = 1; e_lv[c] = s; la[c] = n;
                    if (s) begin e_up[c] = 1; st[c] = 1; ref_ms[c] = n / MSC; end
                    else begin e_dn[c] = 1; e_sh[c] = st[c] == 1; st[c] = 0; end
                end
                if (!acc && n % MSC == 0 && st[c] != 0) begin
                    el = n / MSC - ref_ms[c];
                    if (st[c] == 1 && el == LONG) begin e_lg[c] = 1; st[c] = 2; ref_ms[c] = n / MSC; end
                    else if (st[c] == 2 && MASK[c] && el % REP == 0) e_rp[c] = 1;
                end
            end
        end
    end

    assign obs = {level, trans_up, trans_dn, short_press, long_press, repeat_tick, any_event};
    assign expv = {e_lv, e_up, e_dn, e_sh, e_lg, e_rp, |{e_up, e_dn, e_sh, e_lg, e_rp}};

    task test_reset;
        rst_n = 0; sw = '1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_state got %h want 0", obs); end
        rst_n = 1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL reset_idle cyc %0d got %h want %h", k, obs, expv); end
        end
    endtask

    task test_press_release;
        int up_at, up_n, dn_n, sh_n;
        up_at = -1; up_n = 0; dn_n = 0; sh_n = 0;
        sw[0] = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL press0 cyc %0d got %h want %h", k, obs, expv); end
            if (trans_up[0]) begin up_n++; if (up_at < 0) up_at = k; end
        end
        checks++;
        if (up_at < 18 || up_at > 22) begin errors++; $display("FAIL press0_latency got %0d want 18..22", up_at); end
        checks++;
        if (up_n != 1) begin errors++; $display("FAIL press0_count got %0d want 1", up_n); end
        checks++;
        if (level[0] !== 1'b1) begin errors++; $display("FAIL press0_level got %b want 1", level[0]); end
        sw[0] = 1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL release0 cyc %0d got %h want %h", k, obs, expv); end
            if (trans_dn[0]) begin dn_n++; if (short_press[0]) sh_n++; end
        end
        checks++;
        if (dn_n != 1 || sh_n != 1) begin errors++; $display("FAIL release0_pulses got dn %0d short %0d want 1 1", dn_n, sh_n); end
        checks++;
        if (level[0] !== 1'b0) begin errors++; $display("FAIL release0_level got %b want 0", level[0]); end
    endtask

    task test_bounce;
        int bounce_up, up_n, up_at;
        bounce_up = 0; up_n = 0; up_at = -1;
        for (int k = 0; k < 60; k++) begin
            sw[1] = ((k / 8) % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL bounce1 cyc %0d got %h want %h", k, obs, expv); end
            if (trans_up[1]) bounce_up++;
        end
        sw[1] = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL settle1 cyc %0d got %h want %h", k, obs, expv); end
            if (trans_up[1]) begin up_n++; if (up_at < 0) up_at = k; end
        end
        checks++;
        if (bounce_up != 0) begin errors++; $display("FAIL bounce1_quiet got %0d want 0", bounce_up); end
        checks++;
        if (up_n != 1 || up_at < 18 || up_at > 22) begin errors++; $display("FAIL bounce1_accept got n %0d at %0d want 1 at 18..22", up_n, up_at); end
        sw[1] = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL bounce1_rel cyc %0d got %h want %h", k, obs, expv); end
        end
    endtask

    task test_simultaneous;
        int at0, at1, any_n;
        at0 = -1; at1 = -2; any_n = 0;
        sw[1:0] = 2'b00;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL simul cyc %0d got %h want %h", k, obs, expv); end
            if (trans_up[0]) at0 = k;
            if (trans_up[1]) at1 = k;
            if (any_event) any_n++;
        end
        checks++;
        if (at0 != at1) begin errors++; $display("FAIL simul_same_cycle got %0d and %0d want equal", at0, at1); end
        checks++;
        if (any_n != 1) begin errors++; $display("FAIL simul_any_event got %0d cycles want 1", any_n); end
        sw[1:0] = 2'b11;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL simul_rel cyc %0d got %h want %h", k, obs, expv); end
        end
    endtask

    task test_random;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N; c++) if ($urandom_range(0, 23) == 0) sw[c] = ~sw[c];
            @(negedge clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL random cyc %0d got %h want %h", k, obs, expv); end
        end
        sw = '1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL random_rel cyc %0d got %h want %h", k, obs, expv); end
        end
    endtask

    task test_hold(input int c, input int cyc, input int want_rp);
        int up_at, lg_at, lg_n, rp_n, sh_n, dn_n;
        up_at = 0; lg_at = 0; lg_n = 0; rp_n = 0; sh_n = 0; dn_n = 0;
        for (int k = 0; k < 2 * MSC && n % MSC != 1000; k++) @(negedge clk);
        checks++;
        if (n % MSC != 1000) begin errors++; $display("FAIL hold%0d_align got phase %0d want 1000", c, n % MSC); end
        sw[c] = 0;
        for (int k = 1; k <= cyc; k++) begin
            @(negedge clk);
            if (((obs | expv) & PM) != '0 || k % 64 == 0) begin
                checks++;
                if (obs !== expv) begin errors++; $display("FAIL hold%0d cyc %0d got %h want %h", c, k, obs, expv); end
            end
            if (trans_up[c]) up_at = k;
            if (long_press[c]) begin lg_n++; lg_at = k; end
            if (repeat_tick[c]) rp_n++;
            if (short_press[c]) sh_n++;
        end
        sw[c] = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL hold%0d_rel cyc %0d got %h want %h", c, k, obs, expv); end
            if (trans_dn[c]) dn_n++;
            if (short_press[c]) sh_n++;
        end
        checks++;
        if (lg_n != 1) begin errors++; $display("FAIL hold%0d_long got %0d want 1", c, lg_n); end
        checks++;
        if (lg_at - up_at < 4000 || lg_at - up_at > 8000) begin errors++; $display("FAIL hold%0d_long_delay got %0d want 4000..8000", c, lg_at - up_at); end
        checks++;
        if (rp_n != want_rp) begin errors++; $display("FAIL hold%0d_repeats got %0d want %0d", c, rp_n, want_rp); end
        checks++;
        if (dn_n != 1 || sh_n != 0) begin errors++; $display("FAIL hold%0d_release got dn %0d short %0d want 1 0", c, dn_n, sh_n); end
    endtask

    task test_reset_mid_hold;
        int up_at, up_n;
        up_at = -1; up_n = 0;
        sw[0] = 0;
        for (int k = 0; k < 140; k++) begin
            @(negedge clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL rsthold_pre cyc %0d got %h want %h", k, obs, expv); end
        end
        rst_n = 0;
        #1; checks++;
        if (obs !== '0) begin errors++; $display("FAIL rsthold_async got %h want 0", obs); end
        repeat (3) @(negedge clk);
        rst_n = 1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL rsthold_post cyc %0d got %h want %h", k, obs, expv); end
            if (trans_up[0]) begin up_n++; if (up_at < 0) up_at = k; end
        end
        checks++;
        if (up_n != 1 || up_at < 18 || up_at > 26) begin errors++; $display("FAIL rsthold_reissue got n %0d at %0d want 1 at 18..26", up_n, up_at); end
        sw[0] = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL rsthold_rel cyc %0d got %h want %h", k, obs, expv); end
        end
    endtask

    initial begin
        test_reset;
        test_press_release;
        test_bounce;
        test_simultaneous;
        test_random;
        test_hold(2, 10 * MSC, 8);
        test_hold(3, 6 * MSC, 0);
        test_reset_mid_hold;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
